// File: rtl/connection_aging_scan.sv
// rtl/connection_aging_scan.sv - background sweeper that retires idle entries of the connection aging table
//
// Walks the aging table through its second port while configuration is
// quiescent (aging_enable high). Each live entry whose age reaches
// aging_threshold is reported to the event generator and then marked aged.
//
// Optional feature macro: AGING_SCAN_STATS_EN (adds aged_count / sweep_count).
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   aging_enable        scan permission from the configuration block
//   cur_timestamp       free-running timestamp
//   idx_agingTb         table address (read and write)
//   rdValid_agingTb     one-cycle read strobe
//   wrValid_agingTb     one-cycle write strobe
//   data_agingTb        write data {aged flag, timestamp}
//   ctx_agingTb         read data, valid 2 cycles after rdValid_agingTb
//   agingInfo_valid     aged-connection report valid
//   agingInfo_idx       index of the aged connection
//   agingInfo_ready     event generator accepts the report
//   aged_count          (stats) completed report handshakes, saturating
//   sweep_count         (stats) completed sweeps, wrapping
//   scan_done           one-cycle pulse after the last index is processed

module connection_aging_scan #(
    parameter int                     d_agingTb       = 9,
    parameter int                     w_agingTb       = 9,
    parameter int                     w_timestamp     = 8,
    parameter logic [w_timestamp-1:0] aging_threshold = 8'd100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   aging_enable,
    input  logic [w_timestamp-1:0] cur_timestamp,
    output logic [d_agingTb-1:0]   idx_agingTb,
    output logic                   rdValid_agingTb,
    output logic                   wrValid_agingTb,
    output logic [w_agingTb-1:0]   data_agingTb,
    input  logic [w_agingTb-1:0]   ctx_agingTb,
    output logic                   agingInfo_valid,
    output logic [d_agingTb-1:0]   agingInfo_idx,
    input  logic                   agingInfo_ready,
`ifdef AGING_SCAN_STATS_EN
    output logic [31:0]            aged_count,
    output logic [15:0]            sweep_count,
`endif
    output logic                   scan_done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RAM_1,
        WAIT_RAM_2,
        CHECK,
        REPORT,
        WRITE,
        NEXT
    } state_t;

    localparam logic [d_agingTb-1:0] PTR_ONE  = {{(d_agingTb-1){1'b0}}, 1'b1};
    localparam logic [d_agingTb-1:0] PTR_LAST = {d_agingTb{1'b1}};

    state_t                 state_q;
    logic [d_agingTb-1:0]   ptr_q;
    logic [w_agingTb-1:0]   ctx_q;
    // CHECK spends two cycles: phase 0 captures the read data, phase 1
    // decides from the captured copy so the age compare starts from a flop.
    logic                   chk_phase_q;

    logic [d_agingTb-1:0]   idx_q;
    logic                   rd_q;
    logic                   wr_q;
    logic [w_agingTb-1:0]   data_q;
    logic                   valid_q;
    logic [d_agingTb-1:0]   aidx_q;
    logic                   done_q;

    logic [w_timestamp-1:0] age_d;
    logic                   aged_d;
    logic [w_agingTb-1:0]   wdata_d;
    logic [d_agingTb-1:0]   ptr_d;

    // Age uses modular subtraction so a timestamp that has wrapped still
    // yields the correct distance.
    always_comb begin
        age_d                  = cur_timestamp - ctx_q[w_timestamp-1:0];
        aged_d                 = !ctx_q[w_agingTb-1] && (age_d >= aging_threshold);
        wdata_d                = ctx_q;
        wdata_d[w_agingTb-1]   = 1'b1;
        ptr_d                  = ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            ctx_q       <= '0;
            chk_phase_q <= 1'b0;
            idx_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            aidx_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (aging_enable) state_q <= READ;
                end
                READ: begin
                    if (!aging_enable) begin
                        state_q <= IDLE;
                    end else begin
                        rd_q    <= 1'b1;
                        idx_q   <= ptr_q;
                        state_q <= WAIT_RAM_1;
                    end
                end
                WAIT_RAM_1: begin
                    state_q <= aging_enable ? WAIT_RAM_2 : IDLE;
                end
                WAIT_RAM_2: begin
                    chk_phase_q <= 1'b0;
                    state_q     <= aging_enable ? CHECK : IDLE;
                end
                CHECK: begin
                    if (!aging_enable) begin
                        chk_phase_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (!chk_phase_q) begin
                        ctx_q       <= ctx_agingTb;
                        chk_phase_q <= 1'b1;
                    end else begin
                        chk_phase_q <= 1'b0;
                        if (aged_d) begin
                            valid_q <= 1'b1;
                            aidx_q  <= ptr_q;
                            state_q <= REPORT;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end
                REPORT: begin
                    // Once raised, the report is held until accepted; a
                    // disable seen at acceptance skips the write and keeps
                    // the pointer so the entry is re-checked on resume.
                    if (agingInfo_ready) begin
                        valid_q <= 1'b0;
                        state_q <= aging_enable ? WRITE : IDLE;
                    end
                end
                WRITE: begin
                    wr_q    <= 1'b1;
                    idx_q   <= ptr_q;
                    data_q  <= wdata_d;
                    state_q <= NEXT;
                end
                NEXT: begin
                    ptr_q   <= ptr_d;
                    done_q  <= (ptr_q == PTR_LAST);
                    state_q <= aging_enable ? READ : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idx_agingTb     = idx_q;
    assign rdValid_agingTb = rd_q;
    assign wrValid_agingTb = wr_q;
    assign data_agingTb    = data_q;
    assign agingInfo_valid = valid_q;
    assign agingInfo_idx   = aidx_q;
    assign scan_done       = done_q;

`ifdef AGING_SCAN_STATS_EN
    logic [31:0] aged_count_q;
    logic [15:0] sweep_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aged_count_q  <= '0;
            sweep_count_q <= '0;
        end else begin
            if (state_q == REPORT && agingInfo_ready && aged_count_q != 32'hFFFF_FFFF) begin
                aged_count_q <= aged_count_q + 32'd1;
            end
            if (done_q) begin
                sweep_count_q <= sweep_count_q + 16'd1;
            end
        end
    end

    assign aged_count  = aged_count_q;
    assign sweep_count = sweep_count_q;
`endif

endmodule

// File: doc/connection_aging_scan.md
# connection_aging_scan

Background sweeper for the connection aging table, one stage downstream of the connection/hash table configuration block. It consumes that block's `aging_enable` and walks the aging table through the table's second port. It retires idle connections by emitting their index to the built-in event generator and marking the entry as aged. Scanning runs only while configuration is quiescent (`aging_enable` high) and yields immediately when configuration traffic starts.

## Interface
- `d_agingTb`, 9: aging table address width; the table holds 2^d_agingTb entries.
- `w_agingTb`, 9: entry width. Bit 8 is the deleted/aged flag (1 = inactive); bits [7:0] are the last timestamp.
- `w_timestamp`, 8: timestamp width.
- `aging_threshold`, 8'd100: minimum age, in timestamp ticks, at which an entry is retired.

- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `aging_enable`  in  1  scan permission from the configuration block.
- `cur_timestamp`  in  w_timestamp  free-running timestamp.
- `idx_agingTb`  out  d_agingTb  table address.
- `rdValid_agingTb`  out  1  one-cycle read strobe.
- `wrValid_agingTb`  out  1  one-cycle write strobe.
- `data_agingTb`  out  w_agingTb  write data.
- `ctx_agingTb`  in  w_agingTb  read data, valid 2 cycles after `rdValid_agingTb`.
- `agingInfo_valid`  out  1  aged-connection report valid.
- `agingInfo_idx`  out  d_agingTb  index of the aged connection.
- `agingInfo_ready`  in  1  event generator accepts the report.
- `scan_done`  out  1  one-cycle pulse when the last index has been processed.

## Operation
- States: `IDLE`, `READ`, `WAIT_RAM_1`, `WAIT_RAM_2`, `CHECK`, `REPORT`, `WRITE`, `NEXT`.
- `IDLE` → `READ` when `aging_enable` is 1.
- `READ`: drive `idx_agingTb` = scan pointer, pulse `rdValid_agingTb`.
- `WAIT_RAM_1` → `WAIT_RAM_2` → `CHECK`: read latency.
- `CHECK`: capture `ctx_agingTb`. Compute age = (`cur_timestamp` − ctx[7:0]) mod 2^8, unsigned 8-bit wrap.
  - If ctx[8] is 0 and age ≥ `aging_threshold`: go to `REPORT`.
  - Otherwise: go to `NEXT`.
- `REPORT`: hold `agingInfo_valid`=1 and `agingInfo_idx` = pointer until `agingInfo_ready`=1. The transfer completes on the cycle both are high; then go to `WRITE`.
- `WRITE`: pulse `wrValid_agingTb` with `data_agingTb` = {1'b1, captured ts[7:0]}, then go to `NEXT`.
- `NEXT`: increment the pointer, wrapping from 2^d_agingTb−1 to 0. On wrap, pulse `scan_done`. Return to `READ` if `aging_enable` is 1, else `IDLE`.
- Abort rule: `aging_enable` low in any of `READ`/`WAIT_RAM_*`/`CHECK` → go to `IDLE` without advancing the pointer. The entry is re-read on resume.
- `REPORT` is never abandoned once `agingInfo_valid` has risen. If `aging_enable` is low at handshake completion, go to `IDLE`, skip `WRITE` and keep the pointer, so the entry is re-checked later. A configuration write may have refreshed it meanwhile; duplicate reports are permitted.
- Deleted entries (bit 8 = 1) are never reported.

## Timing
- Reset values: all strobes 0, `agingInfo_valid` 0, `scan_done` 0, `idx_agingTb`/`agingInfo_idx`/`data_agingTb` 0, pointer 0, state `IDLE`.
- Entry that does not age: 6 cycles, `READ` through `NEXT`, back to the next `READ`.
- Aged entry with ready already high: 8 cycles.
- Full sweep with no aged entries: 6·2^d_agingTb cycles.
- Strobes are registered and last exactly one cycle.
- `agingInfo_idx` is stable while `agingInfo_valid` is high.
- Reset asserted mid-operation clears everything within the same cycle, asynchronously. The partial sweep restarts at index 0.

## Configuration
- `AGING_SCAN_STATS_EN` defined:
  - Adds output `aged_count` (32 bits), which increments on every completed report handshake, saturates at 32'hFFFF_FFFF, and resets to 0.
  - Adds output `sweep_count` (16 bits), which increments on `scan_done` and wraps.
- `AGING_SCAN_STATS_EN` undefined: neither port nor its counters exist. All other behaviour is identical.

## Test plan
- Table all 9'h100 (deleted), `aging_enable`=1 → no `agingInfo_valid`; `scan_done` pulses every 3072 cycles.
- Entry 5 = {0, 8'd10}, `cur_timestamp`=8'd120 → `agingInfo_idx`=5, then write to index 5 with data 9'h10A; other entries are untouched.
- Entry 7 = {0, 8'd200}, `cur_timestamp`=8'd44 (age 100, wrap) → reported. With ts 8'd201 (age 99) → not reported.
- `agingInfo_ready` held 0 for 20 cycles on index 3 → valid and idx stay stable; a single write follows ready; the pointer advances to 4.
- `aging_enable` dropped in `WAIT_RAM_2` at index 12 → no write; after re-enable, the first read is at index 12.
- `reset` pulsed in `REPORT` → `agingInfo_valid` is 0 immediately; after release, the scan starts at index 0.
